// File: rtl/uart_mux_pkg.sv
// Shared types for the stream multiplexer/arbiter slice.
//   arb_mode_t  : arbitration policy selector (fixed priority or round-robin)
//   mux_state_t : top-level lock FSM state
//   sel_width() : select-index width, clamped to at least one bit
package uart_mux_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_t;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } mux_state_t;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter for the stream multiplexer.
// Ports:
//   req     in   NUM_CH  request vector (one bit per channel)
//   ptr     in   SEL_W   last granted channel; RR search starts at ptr+1
//   mode    in   1       ARB_FIXED: lowest index wins, ARB_RR: rotating search
//   gnt_idx out  SEL_W   index of the winning channel (0 when nothing requests)
//   gnt_any out  1       at least one request is present
module rr_arbiter
   import uart_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int SEL_W  = sel_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   input  arb_mode_t         mode,
   output logic [SEL_W-1:0]  gnt_idx,
   output logic              gnt_any
);

   logic found;
   int   cand;

   assign gnt_any = |req;

   always_comb begin
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      if (mode == ARB_FIXED) begin
         // Scan downward so the lowest requesting index is the last writer.
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
               gnt_idx = SEL_W'(i);
            end
         end
      end else begin
         // Offsets 1..NUM_CH visit every channel once, the previous owner last.
         for (int k = 1; k <= NUM_CH; k++) begin
            cand = (int'(ptr) + k) % NUM_CH;
            if (!found && req[cand]) begin
               found   = 1'b1;
               gnt_idx = SEL_W'(cand);
            end
         end
      end
   end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel registered stream multiplexer with packet locking.
// One valid/ready source is granted at a time and keeps the grant until a
// beat flagged last is accepted, so frames from different producers never
// interleave on the shared output.
// Ports:
//   clk        in   1             clock, rising edge
//   rst_n      in   1             asynchronous active-low reset
//   in_valid   in   NUM_CH        per-channel beat valid
//   in_last    in   NUM_CH        per-channel end-of-packet, qualified by in_valid
//   in_data    in   NUM_CH*WIDTH  channel k at [k*WIDTH +: WIDTH]
//   in_ready   out  NUM_CH        one-hot (granted channel) or zero
//   out_valid  out  1             registered output valid
//   out_last   out  1             registered end-of-packet
//   out_data   out  WIDTH         registered data
//   out_sel    out  SEL_W         source channel of the current output beat
//   out_ready  in   1             downstream ready
//   busy       out  1             high while a channel holds the lock
//
// state    | meaning
// S_IDLE   | no owner; arbitrate among requesters, in_ready all zero
// S_LOCKED | grant owns the output until its last beat is accepted
module stream_mux_arb
   import uart_mux_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int WIDTH    = 8,
   parameter int ARB_MODE = 1,
   parameter int SEL_W    = sel_width(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH-1:0]       in_last,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]       in_ready,
   output logic                    out_valid,
   output logic                    out_last,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   input  logic                    out_ready,
   output logic                    busy
);

   localparam arb_mode_t        MODE    = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;
   localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NUM_CH - 1);

   mux_state_t       state;
   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] win_idx;
   logic             win_any;

   logic             can_load;
   logic             xfer;
   logic             sel_valid;
   logic             sel_last;
   logic [WIDTH-1:0] sel_data;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_arb (
      .req     (in_valid),
      .ptr     (rr_ptr),
      .mode    (MODE),
      .gnt_idx (win_idx),
      .gnt_any (win_any)
   );

   // Granted-channel view of the inputs.
   always_comb begin
      sel_valid = in_valid[grant];
      sel_last  = in_last[grant];
      sel_data  = in_data[grant*WIDTH +: WIDTH];
   end

   // The output register can take a beat when empty or draining this cycle.
   assign can_load = ~out_valid | out_ready;
   assign busy     = (state == S_LOCKED);
   assign xfer     = busy & sel_valid & can_load;

   always_comb begin
      in_ready = '0;
      if (busy) begin
         in_ready[grant] = can_load;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         grant  <= '0;
         rr_ptr <= PTR_RST;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_any) begin
                  grant <= win_idx;
                  state <= S_LOCKED;
               end
            end
            S_LOCKED: begin
               if (xfer && sel_last) begin
                  state  <= S_IDLE;
                  rr_ptr <= grant;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_last  <= sel_last;
         out_data  <= sel_data;
         out_sel   <= grant;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: instance 0 is fixed priority, instance 1 is
// round-robin. A cycle-level reference model (per-channel FIFOs, an owner
// index and a last-winner index) predicts in_ready and the output register.
module tb_stream_mux_arb;
   import uart_mux_pkg::*;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
   } beat_t;

   typedef struct {
      int sel;
      int d;
      int l;
      int cyc;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   iv [2];
   logic [N-1:0]   il [2];
   logic [N*W-1:0] id [2];
   logic [N-1:0]   ir [2];
   logic           ordy [2];
   logic           ov [2];
   logic           ol [2];
   logic [W-1:0]   od [2];
   logic [SW-1:0]  os [2];
   logic           bsy [2];

   stream_mux_arb #(.NUM_CH(N), .WIDTH(W), .ARB_MODE(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_last(il[0]), .in_data(id[0]),
      .in_ready(ir[0]), .out_valid(ov[0]), .out_last(ol[0]), .out_data(od[0]),
      .out_sel(os[0]), .out_ready(ordy[0]), .busy(bsy[0]));

   stream_mux_arb #(.NUM_CH(N), .WIDTH(W), .ARB_MODE(1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_last(il[1]), .in_data(id[1]),
      .in_ready(ir[1]), .out_valid(ov[1]), .out_last(ol[1]), .out_data(od[1]),
      .out_sel(os[1]), .out_ready(ordy[1]), .busy(bsy[1]));

   int checks = 0;
   int fails  = 0;
   int cycno  = 0;

   beat_t src [2*N][$];
   beat_t refq [2*N][$];
   obs_t  olog [2][$];
   int    xcount [2];
   int    tot [2];

   int vprob [2];
   bit rrand;
   bit ordy_fix [2];

   bit   m_lock [2];
   int   m_gnt [2];
   int   m_ptr [2];
   bit   m_ov [2];
   bit   m_ol [2];
   int   m_od [2];
   int   m_os [2];
   bit   nx_lock [2];
   int   nx_gnt [2];
   int   nx_ptr [2];
   bit   nx_ov [2];
   bit   nx_ol [2];
   int   nx_od [2];
   int   nx_os [2];

   task automatic chk(input int s, input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL inst%0d %s observed=%0h expected=%0h", s, tag, obs, exp);
      end
   endtask

   // Winner: mode 0 lowest index; mode 1 first requester after the last winner.
   function automatic int pick(input int mode, input logic [N-1:0] req, input int ptr);
      if (mode == 0) begin
         for (int i = 0; i < N; i++) if (req[i]) return i;
      end else begin
         for (int k = 1; k <= N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic push_pkt(input int s, input int ch, input int len, input int base);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = W'(base + i);
         b.l = (i == len - 1);
         src[s*N+ch].push_back(b);
         refq[s*N+ch].push_back(b);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         iv[s] = '0; il[s] = '0; id[s] = '0; ordy[s] = 1'b1;
         olog[s].delete();
         xcount[s] = 0; tot[s] = 0;
         m_lock[s] = 0; m_gnt[s] = 0; m_ptr[s] = N - 1;
         m_ov[s] = 0; m_ol[s] = 0; m_od[s] = 0; m_os[s] = 0;
      end
      for (int q = 0; q < 2*N; q++) begin
         src[q].delete();
         refq[q].delete();
      end
      #1;
      for (int s = 0; s < 2; s++) begin
         chk(s, "rst_out_valid", 32'(ov[s]), 0);
         chk(s, "rst_out_last",  32'(ol[s]), 0);
         chk(s, "rst_out_data",  32'(od[s]), 0);
         chk(s, "rst_out_sel",   32'(os[s]), 0);
         chk(s, "rst_busy",      32'(bsy[s]), 0);
         chk(s, "rst_in_ready",  32'(ir[s]), 0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One clock: drive inputs, check in_ready, step the model, check outputs.
   task automatic do_cycle();
      logic [N-1:0] rdy;
      bit xf;
      int g;
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < N; k++) begin
            if (src[s*N+k].size() > 0 && $urandom_range(99) < vprob[s]) begin
               iv[s][k] = 1'b1;
               il[s][k] = src[s*N+k][0].l;
               id[s][k*W +: W] = src[s*N+k][0].d;
            end else begin
               iv[s][k] = 1'b0;
               il[s][k] = 1'($urandom_range(1));
               id[s][k*W +: W] = W'($urandom);
            end
         end
         ordy[s] = rrand ? ($urandom_range(99) < 70) : ordy_fix[s];
      end
      #1;
      for (int s = 0; s < 2; s++) begin
         g = m_gnt[s];
         rdy = '0;
         if (m_lock[s] && (!m_ov[s] || ordy[s])) rdy[g] = 1'b1;
         chk(s, "in_ready", 32'(ir[s]), 32'(rdy));
         chk(s, "busy", 32'(bsy[s]), 32'(m_lock[s]));
         nx_lock[s] = m_lock[s]; nx_gnt[s] = m_gnt[s]; nx_ptr[s] = m_ptr[s];
         nx_ov[s] = m_ov[s]; nx_ol[s] = m_ol[s]; nx_od[s] = m_od[s]; nx_os[s] = m_os[s];
         if (m_ov[s] && ordy[s]) begin
            olog[s].push_back('{sel: int'(os[s]), d: int'(od[s]), l: int'(ol[s]), cyc: cycno});
            if (refq[s*N+m_os[s]].size() > 0) begin
               chk(s, "sb_data", 32'(od[s]), 32'(refq[s*N+m_os[s]][0].d));
               chk(s, "sb_last", 32'(ol[s]), 32'(refq[s*N+m_os[s]][0].l));
               void'(refq[s*N+m_os[s]].pop_front());
            end else begin
               chk(s, "sb_unexpected_beat", 1, 0);
            end
         end
         xf = m_lock[s] && iv[s][g] && rdy[g];
         if (!m_lock[s]) begin
            if (iv[s] != '0) begin
               nx_gnt[s]  = pick(s, iv[s], m_ptr[s]);
               nx_lock[s] = 1;
            end
         end else if (xf && il[s][g]) begin
            nx_lock[s] = 0;
            nx_ptr[s]  = g;
         end
         if (xf) begin
            nx_ov[s] = 1;
            nx_od[s] = int'(id[s][g*W +: W]);
            nx_ol[s] = il[s][g];
            nx_os[s] = g;
            void'(src[s*N+g].pop_front());
            xcount[s]++;
         end else if (m_ov[s] && ordy[s]) begin
            nx_ov[s] = 0;
         end
      end
      @(posedge clk);
      cycno++;
      #1;
      for (int s = 0; s < 2; s++) begin
         m_lock[s] = nx_lock[s]; m_gnt[s] = nx_gnt[s]; m_ptr[s] = nx_ptr[s];
         m_ov[s] = nx_ov[s]; m_ol[s] = nx_ol[s]; m_od[s] = nx_od[s]; m_os[s] = nx_os[s];
         chk(s, "out_valid", 32'(ov[s]), 32'(m_ov[s]));
         if (m_ov[s]) begin
            chk(s, "out_data", 32'(od[s]), 32'(m_od[s]));
            chk(s, "out_last", 32'(ol[s]), 32'(m_ol[s]));
            chk(s, "out_sel",  32'(os[s]), 32'(m_os[s]));
         end
      end
   endtask

   task automatic run_until(input int s, input int n, input int budget, input string tag);
      int b = 0;
      while (olog[s].size() < n && b < budget) begin
         do_cycle();
         b++;
      end
      chk(s, tag, olog[s].size(), n);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int e_rr [5];
      logic [W-1:0] hold;
      e_rr = '{0, 1, 2, 3, 0};
      rrand = 0;
      for (int s = 0; s < 2; s++) begin vprob[s] = 100; ordy_fix[s] = 1; end

      // Reset mid-packet, then ch0 wins the first arbitration.
      do_reset();
      push_pkt(1, 2, 2, 'hA1);
      b = 0;
      while (xcount[1] == 0 && b < 10) begin do_cycle(); b++; end
      chk(1, "rst_mid_accept", xcount[1], 1);
      chk(1, "rst_mid_ov_before", 32'(ov[1]), 1);
      rst_n = 1'b0;
      #1;
      chk(1, "rst_mid_ov_async", 32'(ov[1]), 0);
      do_reset();
      push_pkt(1, 3, 1, 'h35);
      push_pkt(1, 0, 1, 'h05);
      run_until(1, 2, 20, "rst_after_count");
      if (olog[1].size() >= 2) begin
         chk(1, "rst_after_first_sel", olog[1][0].sel, 0);
         chk(1, "rst_after_second_sel", olog[1][1].sel, 3);
      end

      // Round-robin fairness with all channels requesting single-beat packets.
      do_reset();
      for (int k = 0; k < N; k++) for (int p = 0; p < 3; p++) push_pkt(1, k, 1, 'h20 + 16*k + p);
      run_until(1, 5, 40, "rr_count");
      if (olog[1].size() >= 5) begin
         for (int i = 0; i < 5; i++) chk(1, "rr_seq_sel", olog[1][i].sel, e_rr[i]);
         for (int i = 1; i < 5; i++) chk(1, "rr_gap", olog[1][i].cyc - olog[1][i-1].cyc, 2);
      end

      // Packet lock: ch1 holds the output for all three beats while ch0 waits.
      do_reset();
      push_pkt(1, 1, 3, 'h10);
      do_cycle();
      push_pkt(1, 0, 1, 'h77);
      run_until(1, 4, 30, "lock_count");
      if (olog[1].size() >= 4) begin
         chk(1, "lock_sel0", olog[1][0].sel, 1);
         chk(1, "lock_sel1", olog[1][1].sel, 1);
         chk(1, "lock_sel2", olog[1][2].sel, 1);
         chk(1, "lock_sel3", olog[1][3].sel, 0);
         chk(1, "lock_d2", olog[1][2].d, 'h12);
         chk(1, "lock_d3", olog[1][3].d, 'h77);
      end

      // Backpressure: five stalled cycles mid-packet.
      do_reset();
      push_pkt(1, 2, 4, 'h30);
      run_until(1, 2, 20, "bp_pre_count");
      hold = od[1];
      ordy_fix[1] = 0;
      for (int i = 0; i < 5; i++) begin
         do_cycle();
         chk(1, "bp_hold_data", 32'(od[1]), 32'(hold));
         chk(1, "bp_hold_valid", 32'(ov[1]), 1);
         chk(1, "bp_in_ready", 32'(ir[1][2]), 0);
      end
      ordy_fix[1] = 1;
      run_until(1, 4, 20, "bp_post_count");
      repeat (6) do_cycle();
      chk(1, "bp_no_dup", olog[1].size(), 4);
      for (int i = 0; i < 4 && i < olog[1].size(); i++) chk(1, "bp_order", olog[1][i].d, 'h30 + i);

      // Fixed priority: ch1 beats ch3 every time it requests.
      do_reset();
      for (int p = 0; p < 3; p++) begin
         push_pkt(0, 3, 1, 'h60 + p);
         push_pkt(0, 1, 1, 'h40 + p);
      end
      run_until(0, 6, 40, "fp_count");
      for (int i = 0; i < 6 && i < olog[0].size(); i++)
         chk(0, "fp_sel", olog[0][i].sel, (i < 3) ? 1 : 3);

      // Latency: request in cycle 0, ready in cycle 1, output in cycle 2.
      do_reset();
      push_pkt(1, 2, 1, 'h5A);
      do_cycle();
      chk(1, "lat_in_ready_c1", 32'(ir[1]), 32'(4'b0100));
      chk(1, "lat_ov_c1", 32'(ov[1]), 0);
      do_cycle();
      chk(1, "lat_ov_c2", 32'(ov[1]), 1);
      chk(1, "lat_data_c2", 32'(od[1]), 'h5A);
      chk(1, "lat_sel_c2", 32'(os[1]), 2);
      chk(1, "lat_last_c2", 32'(ol[1]), 1);

      // Random traffic on both instances.
      do_reset();
      rrand = 1;
      vprob[0] = 70; vprob[1] = 70;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(99) < 15) begin
            int s, ch, len;
            s = int'($urandom_range(1));
            ch = int'($urandom_range(N - 1));
            len = int'($urandom_range(4, 1));
            if (src[s*N+ch].size() < 6) begin
               push_pkt(s, ch, len, int'($urandom_range(255)));
               tot[s] += len;
            end
         end
         do_cycle();
      end
      rrand = 0;
      vprob[0] = 100; vprob[1] = 100;
      ordy_fix[0] = 1; ordy_fix[1] = 1;
      b = 0;
      while (b < 400) begin
         bit pending;
         pending = m_ov[0] || m_ov[1] || m_lock[0] || m_lock[1];
         for (int q = 0; q < 2*N; q++) if (src[q].size() > 0) pending = 1;
         if (!pending) break;
         do_cycle();
         b++;
      end
      chk(0, "rand_total_beats", olog[0].size(), tot[0]);
      chk(1, "rand_total_beats", olog[1].size(), tot[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
